// File: rtl/song_pkg.sv
// Shared widths, FSM encoding and ROM contents for the song reader.
// The song table is a constant function, so the ROM synthesises to logic or a ROM macro without a memory file.
package song_pkg;

    localparam int NOTE_W     = 6;
    localparam int DUR_W      = 6;
    localparam int IDX_W      = 5;
    localparam int SONG_COUNT = 4;
    localparam int SONG_W     = $clog2(SONG_COUNT);
    localparam int ROM_W      = NOTE_W + DUR_W;
    localparam int ADDR_W     = SONG_W + IDX_W;

    localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    // Song table: note = 10*song + index, duration = index + 8 beats;
    // song 0 entry 3 carries a zero duration (end marker when that feature is built in).
    function automatic logic [ROM_W-1:0] rom_entry(input logic [SONG_W-1:0] song,
                                                   input logic [IDX_W-1:0]  idx);
        logic [NOTE_W-1:0] note_v;
        logic [DUR_W-1:0]  dur_v;
        note_v = ({4'b0000, song} * 6'd10) + {1'b0, idx};
        if ((song == 2'd0) && (idx == 5'd3)) begin
            dur_v = 6'd0;
        end else begin
            dur_v = {1'b0, idx} + 6'd8;
        end
        return {note_v, dur_v};
    endfunction

endpackage

// File: rtl/song_rom.sv
// Synchronous-read song ROM, addressed by {song, index}; data appears one cycle after the address.
module song_rom
    import song_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] addr,
    output logic [ROM_W-1:0]  data
);

    logic [ROM_W-1:0] data_r;

    // Registered ROM read port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_r <= {ROM_W{1'b0}};
        end else begin
            data_r <= rom_entry(addr[ADDR_W-1:IDX_W], addr[IDX_W-1:0]);
        end
    end

    assign data = data_r;

endmodule

// File: rtl/song_reader.sv
// Walks the song ROM one note at a time, handing note/duration pairs to the note player.
// Optional build macro: SONG_READER_END_MARKER_EN (a zero-duration entry ends the song early).
module song_reader
    import song_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              play,
    input  logic              reset_player,
    input  logic [1:0]        song,
    input  logic              note_done,
    output logic [NOTE_W-1:0] note,
    output logic [DUR_W-1:0]  duration,
    output logic              new_note,
    output logic              song_done,
    output logic [IDX_W-1:0]  note_index
);

    state_t            state_r;
    logic [IDX_W-1:0]  note_index_r;
    logic [IDX_W-1:0]  idx_next_s;
    logic [NOTE_W-1:0] note_r;
    logic [DUR_W-1:0]  duration_r;
    logic              new_note_r;
    logic              song_done_r;
    logic [ROM_W-1:0]  rom_data_s;
    logic [NOTE_W-1:0] rom_note_s;
    logic [DUR_W-1:0]  rom_dur_s;

    // The ROM is addressed with the index being loaded this edge, so its
    // output during FETCH already belongs to the entry about to be issued.
    song_rom u_rom (
        .clk     (clk),
        .reset_n (reset_n),
        .addr    ({song, idx_next_s}),
        .data    (rom_data_s)
    );

    assign rom_note_s = rom_data_s[ROM_W-1:DUR_W];
    assign rom_dur_s  = rom_data_s[DUR_W-1:0];

`ifdef SONG_READER_END_MARKER_EN
    logic end_marker_s;
    assign end_marker_s = (rom_dur_s == {DUR_W{1'b0}});
`endif

    // Next note index: restart, advance on note_done in WAIT, wrap only at song end.
    always_comb begin
        idx_next_s = note_index_r;
        if (reset_player) begin
            idx_next_s = {IDX_W{1'b0}};
        end else begin
            case (state_r)
                ST_WAIT: begin
                    if (note_done) begin
                        if (note_index_r == IDX_LAST) begin
                            idx_next_s = {IDX_W{1'b0}};
                        end else begin
                            idx_next_s = note_index_r + IDX_ONE;
                        end
                    end else begin
                        idx_next_s = note_index_r;
                    end
                end
`ifdef SONG_READER_END_MARKER_EN
                ST_FETCH: begin
                    if (play && end_marker_s) begin
                        idx_next_s = {IDX_W{1'b0}};
                    end else begin
                        idx_next_s = note_index_r;
                    end
                end
`endif
                default: idx_next_s = note_index_r;
            endcase
        end
    end

    // Control FSM with registered note/duration/strobe outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            note_index_r <= {IDX_W{1'b0}};
            note_r       <= {NOTE_W{1'b0}};
            duration_r   <= {DUR_W{1'b0}};
            new_note_r   <= 1'b0;
            song_done_r  <= 1'b0;
        end else begin
            new_note_r   <= 1'b0;
            song_done_r  <= 1'b0;
            note_index_r <= idx_next_s;
            if (reset_player) begin
                state_r <= ST_IDLE;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (play) begin
                            state_r <= ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        if (play) begin
`ifdef SONG_READER_END_MARKER_EN
                            if (end_marker_s) begin
                                state_r     <= ST_IDLE;
                                song_done_r <= 1'b1;
                            end else begin
                                note_r     <= rom_note_s;
                                duration_r <= rom_dur_s;
                                new_note_r <= 1'b1;
                                state_r    <= ST_ISSUE;
                            end
`else
                            note_r     <= rom_note_s;
                            duration_r <= rom_dur_s;
                            new_note_r <= 1'b1;
                            state_r    <= ST_ISSUE;
`endif
                        end
                    end
                    ST_ISSUE: begin
                        if (play) begin
                            state_r <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        // A finished note is honoured even while paused.
                        if (note_done) begin
                            if (note_index_r == IDX_LAST) begin
                                song_done_r <= 1'b1;
                                state_r     <= ST_IDLE;
                            end else begin
                                state_r <= ST_FETCH;
                            end
                        end
                    end
                    default: state_r <= ST_IDLE;
                endcase
            end
        end
    end

    assign note       = note_r;
    assign duration   = duration_r;
    assign new_note   = new_note_r;
    assign song_done  = song_done_r;
    assign note_index = note_index_r;

endmodule

// File: tb/tb_song_reader.sv
// Directed bench for song_reader: scoreboard of expected note/duration pairs checked on every new_note.
module tb_song_reader;

    logic       clk;
    logic       reset_n;
    logic       play;
    logic       reset_player;
    logic [1:0] song;
    logic       note_done;
    logic [5:0] note;
    logic [5:0] duration;
    logic       new_note;
    logic       song_done;
    logic [4:0] note_index;

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];

    song_reader dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .play         (play),
        .reset_player (reset_player),
        .song         (song),
        .note_done    (note_done),
        .note         (note),
        .duration     (duration),
        .new_note     (new_note),
        .song_done    (song_done),
        .note_index   (note_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] exp_word(input int s, input int i);
        logic [5:0] n;
        logic [5:0] d;
        n = 6'(s * 10 + i);
        d = (s == 0 && i == 3) ? 6'd0 : 6'(i + 8);
        return {n, d};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Scoreboard: every new_note must match the oldest expected entry.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && new_note !== 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                assert (1'b0) else begin
                    errors++;
                    $error("FAIL unexpected_new_note: observed note %0d dur %0d expected no strobe", note, duration);
                end
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                assert ({note, duration} === e) else begin
                    errors++;
                    $error("FAIL issue_word: observed note %0d dur %0d expected note %0d dur %0d",
                           note, duration, e[11:6], e[5:0]);
                end
            end
        end
    end

    task automatic wait_new_note();
        int n = 0;
        while (new_note !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
        end
        check("new_note_seen", 32'(new_note), 32'd1);
    endtask

    task automatic play_entry(input int s, input int i, input bit finish_note);
        exp_q.push_back(exp_word(s, i));
        wait_new_note();
        check("note_index", 32'(note_index), 32'(i));
        @(negedge clk);
        if (finish_note) begin
            note_done = 1'b1;
            @(negedge clk);
            note_done = 1'b0;
        end
    endtask

    initial begin
        reset_n = 1'b0; play = 1'b0; reset_player = 1'b0; song = 2'd0; note_done = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_note", 32'(note), 32'd0);
        check("rst_duration", 32'(duration), 32'd0);
        check("rst_new_note", 32'(new_note), 32'd0);
        check("rst_song_done", 32'(song_done), 32'd0);
        check("rst_index", 32'(note_index), 32'd0);
        reset_n = 1'b1;

        // Basic issue latency on song 2
        song = 2'd2; play = 1'b1;
        exp_q.push_back(exp_word(2, 0));
        @(negedge clk);
        check("latency_early", 32'(new_note), 32'd0);
        @(negedge clk);
        check("latency_strobe", 32'(new_note), 32'd1);
        check("basic_note", 32'(note), 32'd20);
        check("basic_duration", 32'(duration), 32'd8);
        @(negedge clk);
        check("strobe_width", 32'(new_note), 32'd0);
        check("state_wait", 32'(dut.state_r), 32'd3);
        reset_player = 1'b1; play = 1'b0;
        @(negedge clk);
        reset_player = 1'b0;
        check("restart_state", 32'(dut.state_r), 32'd0);
        check("restart_note_held", 32'(note), 32'd20);

        // Walk all 32 entries of song 1
        song = 2'd1; play = 1'b1;
        for (int i = 0; i < 31; i++) play_entry(1, i, 1'b1);
        play_entry(1, 31, 1'b0);
        play = 1'b0; note_done = 1'b1;
        @(negedge clk);
        note_done = 1'b0;
        check("end_song_done", 32'(song_done), 32'd1);
        check("end_index", 32'(note_index), 32'd0);
        check("end_state", 32'(dut.state_r), 32'd0);
        check("end_new_note", 32'(new_note), 32'd0);
        @(negedge clk);
        check("end_done_width", 32'(song_done), 32'd0);
        check("end_state_hold", 32'(dut.state_r), 32'd0);

        // Pause in FETCH, then in ISSUE; note_done outside WAIT ignored
        play = 1'b1;
        exp_q.push_back(exp_word(1, 0));
        @(negedge clk);
        play = 1'b0;
        check("pause_fetch_state", 32'(dut.state_r), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("pause_fetch_quiet", 32'(new_note), 32'd0);
        end
        play = 1'b1;
        @(negedge clk);
        check("resume_strobe", 32'(new_note), 32'd1);
        play = 1'b0; note_done = 1'b1;
        @(negedge clk);
        note_done = 1'b0;
        check("ignored_done_index", 32'(note_index), 32'd0);
        check("pause_issue_state", 32'(dut.state_r), 32'd2);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("pause_issue_quiet", 32'(new_note), 32'd0);
        end
        check("pause_issue_hold", 32'(dut.state_r), 32'd2);
        play = 1'b1;
        @(negedge clk);
        check("resume_wait", 32'(dut.state_r), 32'd3);
        play = 1'b0; note_done = 1'b1;
        @(negedge clk);
        note_done = 1'b0;
        check("paused_done_index", 32'(note_index), 32'd1);
        check("paused_done_state", 32'(dut.state_r), 32'd1);
        @(negedge clk);
        check("paused_fetch_hold", 32'(dut.state_r), 32'd1);

        // Restart priority over note_done at the last entry
        play = 1'b1;
        for (int i = 1; i < 31; i++) play_entry(1, i, 1'b1);
        play_entry(1, 31, 1'b0);
        note_done = 1'b1; reset_player = 1'b1; play = 1'b0;
        @(negedge clk);
        note_done = 1'b0; reset_player = 1'b0;
        check("prio_index", 32'(note_index), 32'd0);
        check("prio_song_done", 32'(song_done), 32'd0);
        check("prio_state", 32'(dut.state_r), 32'd0);
        @(negedge clk);
        check("prio_song_done_late", 32'(song_done), 32'd0);

        // Zero-duration entry 3 of song 0
        song = 2'd0; play = 1'b1;
        for (int i = 0; i < 3; i++) play_entry(0, i, 1'b1);
`ifdef SONG_READER_END_MARKER_EN
        @(negedge clk);
        play = 1'b0;
        check("marker_song_done", 32'(song_done), 32'd1);
        check("marker_index", 32'(note_index), 32'd0);
        check("marker_state", 32'(dut.state_r), 32'd0);
        check("marker_note_held", 32'(note), 32'd2);
        check("marker_dur_held", 32'(duration), 32'd10);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("marker_quiet", 32'(new_note | song_done), 32'd0);
        end
`else
        play_entry(0, 3, 1'b0);
        check("zero_dur_issued", 32'(duration), 32'd0);
        check("zero_dur_note", 32'(note), 32'd3);
        reset_player = 1'b1; play = 1'b0;
        @(negedge clk);
        reset_player = 1'b0;
`endif

        // Asynchronous reset in the middle of WAIT
        song = 2'd3; reset_player = 1'b1;
        @(negedge clk);
        reset_player = 1'b0; play = 1'b1;
        play_entry(3, 0, 1'b0);
        play = 1'b0;
        check("pre_reset_note", 32'(note), 32'd30);
        #2 reset_n = 1'b0;
        #1;
        check("async_note", 32'(note), 32'd0);
        check("async_duration", 32'(duration), 32'd0);
        check("async_new_note", 32'(new_note), 32'd0);
        check("async_song_done", 32'(song_done), 32'd0);
        check("async_index", 32'(note_index), 32'd0);
        check("async_state", 32'(dut.state_r), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
